// File: rtl/regwrite_port_arbiter_if.sv
// Signal bundle between the two writeback requesters and the register-file write port.
// The arbiter uses the slave modport; the requester side uses master.
interface regwrite_port_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              v0;
  logic [ADDR_W-1:0] rt0;
  logic [ADDR_W-1:0] rd0;
  logic [1:0]        dsel0;
  logic [DATA_W-1:0] data0;
  logic              rdy0;

  logic              v1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic              rdy1;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [1:0]        grant;

  modport master (
    output v0, rt0, rd0, dsel0, data0, v1, addr1, data1,
    input  rdy0, rdy1, rf_we, rf_waddr, rf_wdata, grant
  );

  modport slave (
    input  v0, rt0, rd0, dsel0, data0, v1, addr1, data1,
    output rdy0, rdy1, rf_we, rf_waddr, rf_wdata, grant
  );
endinterface

// File: rtl/regwrite_port_arbiter.sv
// Arbitrates the single register-file write port between core writeback (port 0) and mult/div (port 1).
// Define REGWRITE_FAIR_EN to add the anti-starvation FSM; otherwise port 0 has strict priority.
module regwrite_port_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  regwrite_port_arbiter_if.slave port_io
);

  if (MAX_WAIT < 1) begin : gen_max_wait_check
    $error("MAX_WAIT must be at least 1");
  end

  logic              rdy0, rdy1;
  logic              xfer0, xfer1;
  logic [ADDR_W-1:0] dest0;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [1:0]        grant_q, grant_d;

  always_comb begin
    case (port_io.dsel0)
      2'b01:   dest0 = port_io.rd0;
      2'b10:   dest0 = ADDR_W'(31);
      default: dest0 = port_io.rt0;
    endcase
  end

`ifdef REGWRITE_FAIR_EN
  localparam logic [0:0] S_P0 = 1'b0;
  localparam logic [0:0] S_P1 = 1'b1;
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  // Ready is forced low during reset so a pending request is retried afterwards.
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (rst_n) begin
      if (state_q == S_P1) begin
        rdy1 = port_io.v1;
        rdy0 = port_io.v0 & ~port_io.v1;
      end else begin
        rdy0 = port_io.v0;
        rdy1 = port_io.v1 & ~port_io.v0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (!port_io.v1 || rdy1) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CntW'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    case (state_q)
      S_P0: begin
        if (port_io.v1 && !rdy1 && (wait_cnt_q == CntW'(MAX_WAIT - 1))) state_d = S_P1;
      end
      S_P1: begin
        if (!port_io.v1 || rdy1) state_d = S_P0;
      end
      default: state_d = S_P0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_P0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  always_comb begin
    rdy0 = rst_n & port_io.v0;
    rdy1 = rst_n & port_io.v1 & ~port_io.v0;
  end
`endif

  assign xfer0 = port_io.v0 & rdy0;
  assign xfer1 = port_io.v1 & rdy1;

  // Address/data follow the winner even for $0; only the write enable is suppressed.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    grant_d    = 2'b00;
    if (xfer0) begin
      rf_we_d    = (dest0 != '0);
      rf_waddr_d = dest0;
      rf_wdata_d = port_io.data0;
      grant_d    = 2'b01;
    end else if (xfer1) begin
      rf_we_d    = (port_io.addr1 != '0);
      rf_waddr_d = port_io.addr1;
      rf_wdata_d = port_io.data1;
      grant_d    = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_q    <= 2'b00;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_q    <= grant_d;
    end
  end

  assign port_io.rdy0     = rdy0;
  assign port_io.rdy1     = rdy1;
  assign port_io.rf_we    = rf_we_q;
  assign port_io.rf_waddr = rf_waddr_q;
  assign port_io.rf_wdata = rf_wdata_q;
  assign port_io.grant    = grant_q;

endmodule

// File: tb/tb_regwrite_port_arbiter.sv
// Scoreboard bench for regwrite_port_arbiter; picks the fair or strict scenario from REGWRITE_FAIR_EN.
module tb_regwrite_port_arbiter;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned MAX_WAIT = 4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        grant;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regwrite_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regwrite_port_arbiter #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .port_io(bus)
  );

  exp_t              sb[$];
  exp_t              exp_e;
  exp_t              act;
  int                n_total = 0;
  int                n_pass  = 0;
  logic [ADDR_W-1:0] last_waddr = '0;
  logic [DATA_W-1:0] last_wdata = '0;

  function automatic void push_xfer(input bit p1, input logic [ADDR_W-1:0] a,
                                    input logic [DATA_W-1:0] d);
    sb.push_back({(a != '0), a, d, (p1 ? 2'b10 : 2'b01)});
    last_waddr = a;
    last_wdata = d;
  endfunction

  function automatic void push_idle();
    sb.push_back({1'b0, last_waddr, last_wdata, 2'b00});
  endfunction

  function automatic void push_reset();
    sb.push_back('0);
    last_waddr = '0;
    last_wdata = '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.v0 = 1'b1; bus.rt0 = 5'd5; bus.rd0 = 5'd9; bus.dsel0 = 2'b00; bus.data0 = 32'h1111_2222;
    bus.v1 = 1'b1; bus.addr1 = 5'd7; bus.data1 = 32'h3333_4444;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if ({bus.rdy0, bus.rdy1} !== 2'b00)
        $display("FAIL reset_rdy[%0d]: got %b want 00", i, {bus.rdy0, bus.rdy1});
      else n_pass++;
      push_reset();
      tick();
      act = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant};
      n_total++;
      if (sb.size() == 0) $display("FAIL reset_out[%0d]: scoreboard empty", i);
      else begin
        exp_e = sb.pop_front();
        if (act !== exp_e) $display("FAIL reset_out[%0d]: got %h want %h", i, act, exp_e);
        else n_pass++;
      end
    end
    rst_n = 1'b1;
    bus.v0 = 1'b0;
    bus.v1 = 1'b0;
  endtask

  task automatic test_p0_dest();
    logic [ADDR_W-1:0] exp_addr [4];
    exp_addr[0] = 5'd5; exp_addr[1] = 5'd9; exp_addr[2] = 5'd31; exp_addr[3] = 5'd5;
    bus.rt0 = 5'd5; bus.rd0 = 5'd9; bus.data0 = 32'hDEAD_0001;
    for (int i = 0; i < 5; i++) begin
      bus.v0 = (i < 4);
      bus.dsel0 = 2'(i);
      #1;
      n_total++;
      if ({bus.rdy0, bus.rdy1} !== ((i < 4) ? 2'b10 : 2'b00))
        $display("FAIL p0_rdy[%0d]: got %b", i, {bus.rdy0, bus.rdy1});
      else n_pass++;
      if (i < 4) push_xfer(1'b0, exp_addr[i], 32'hDEAD_0001);
      else push_idle();
      tick();
      act = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant};
      n_total++;
      if (sb.size() == 0) $display("FAIL p0_out[%0d]: scoreboard empty", i);
      else begin
        exp_e = sb.pop_front();
        if (act !== exp_e) $display("FAIL p0_out[%0d]: got %h want %h", i, act, exp_e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_zero_suppress();
    bus.addr1 = 5'd0; bus.data1 = 32'h0000_1234;
    for (int i = 0; i < 2; i++) begin
      bus.v1 = (i == 0);
      #1;
      n_total++;
      if ({bus.rdy0, bus.rdy1} !== ((i == 0) ? 2'b01 : 2'b00))
        $display("FAIL zero_rdy[%0d]: got %b", i, {bus.rdy0, bus.rdy1});
      else n_pass++;
      if (i == 0) push_xfer(1'b1, 5'd0, 32'h0000_1234);
      else push_idle();
      tick();
      act = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant};
      n_total++;
      if (sb.size() == 0) $display("FAIL zero_out[%0d]: scoreboard empty", i);
      else begin
        exp_e = sb.pop_front();
        if (act !== exp_e) $display("FAIL zero_out[%0d]: got %h want %h", i, act, exp_e);
        else n_pass++;
      end
    end
  endtask

`ifdef REGWRITE_FAIR_EN
  // Port 0 wins MAX_WAIT times, then port 1 is forced through; pattern repeats.
  task automatic test_fair_rotation();
    bit p1_turn;
    bus.rt0 = 5'd3; bus.dsel0 = 2'b00; bus.addr1 = 5'd7; bus.data1 = 32'hCAFE_0007;
    for (int i = 0; i < 11; i++) begin
      bus.v0 = (i < 10);
      bus.v1 = (i < 10);
      bus.data0 = 32'h1000_0000 + i;
      p1_turn = ((i % 5) == 4);
      #1;
      n_total++;
      if ({bus.rdy0, bus.rdy1} !== ((i == 10) ? 2'b00 : (p1_turn ? 2'b01 : 2'b10)))
        $display("FAIL fair_rdy[%0d]: got %b", i, {bus.rdy0, bus.rdy1});
      else n_pass++;
      if (i == 10) push_idle();
      else if (p1_turn) push_xfer(1'b1, 5'd7, 32'hCAFE_0007);
      else push_xfer(1'b0, 5'd3, 32'h1000_0000 + i);
      tick();
      act = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant};
      n_total++;
      if (sb.size() == 0) $display("FAIL fair_out[%0d]: scoreboard empty", i);
      else begin
        exp_e = sb.pop_front();
        if (act !== exp_e) $display("FAIL fair_out[%0d]: got %h want %h", i, act, exp_e);
        else n_pass++;
      end
    end
  endtask
`else
  // Port 1 starves while port 0 stays valid, and wins the same cycle port 0 drops.
  task automatic test_strict_priority();
    bus.rt0 = 5'd3; bus.dsel0 = 2'b00; bus.addr1 = 5'd7; bus.data1 = 32'hCAFE_0007;
    for (int i = 0; i < 22; i++) begin
      bus.v0 = (i < 20);
      bus.v1 = (i < 21);
      bus.data0 = 32'h2000_0000 + i;
      #1;
      n_total++;
      if ({bus.rdy0, bus.rdy1} !== ((i < 20) ? 2'b10 : ((i == 20) ? 2'b01 : 2'b00)))
        $display("FAIL strict_rdy[%0d]: got %b", i, {bus.rdy0, bus.rdy1});
      else n_pass++;
      if (i < 20) push_xfer(1'b0, 5'd3, 32'h2000_0000 + i);
      else if (i == 20) push_xfer(1'b1, 5'd7, 32'hCAFE_0007);
      else push_idle();
      tick();
      act = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant};
      n_total++;
      if (sb.size() == 0) $display("FAIL strict_out[%0d]: scoreboard empty", i);
      else begin
        exp_e = sb.pop_front();
        if (act !== exp_e) $display("FAIL strict_out[%0d]: got %h want %h", i, act, exp_e);
        else n_pass++;
      end
    end
  endtask
`endif

  // Four contended grants (fair build ends up preferring port 1), then reset mid-stream.
  // After release port 0 must win again, proving the priority state was cleared.
  task automatic test_reset_midstream();
    logic [1:0] want_rdy;
    bus.rt0 = 5'd12; bus.dsel0 = 2'b00; bus.addr1 = 5'd20; bus.data1 = 32'h5555_AAAA;
    for (int i = 0; i < 8; i++) begin
      rst_n = (i != 4);
      bus.v0 = (i < 6);
      bus.v1 = (i < 7);
      bus.data0 = 32'h3000_0000 + i;
      if (i == 4) want_rdy = 2'b00;
      else if (i < 6) want_rdy = 2'b10;
      else if (i == 6) want_rdy = 2'b01;
      else want_rdy = 2'b00;
      #1;
      n_total++;
      if ({bus.rdy0, bus.rdy1} !== want_rdy)
        $display("FAIL rstmid_rdy[%0d]: got %b want %b", i, {bus.rdy0, bus.rdy1}, want_rdy);
      else n_pass++;
      if (i == 4) push_reset();
      else if (i < 6) push_xfer(1'b0, 5'd12, 32'h3000_0000 + i);
      else if (i == 6) push_xfer(1'b1, 5'd20, 32'h5555_AAAA);
      else push_idle();
      tick();
      act = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant};
      n_total++;
      if (sb.size() == 0) $display("FAIL rstmid_out[%0d]: scoreboard empty", i);
      else begin
        exp_e = sb.pop_front();
        if (act !== exp_e) $display("FAIL rstmid_out[%0d]: got %h want %h", i, act, exp_e);
        else n_pass++;
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_p0_dest();
    test_zero_suppress();
`ifdef REGWRITE_FAIR_EN
    test_fair_rotation();
`else
    test_strict_priority();
`endif
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
